// File: rtl/pia_bus_pkg.sv
// Shared types and constants for the 6800-style PIA register bus.
package pia_bus_pkg;

    localparam logic [1:0] RS_PORTA = 2'd0;
    localparam logic [1:0] RS_CTRLA = 2'd1;
    localparam logic [1:0] RS_PORTB = 2'd2;
    localparam logic [1:0] RS_CTRLB = 2'd3;

    localparam int DDR_SEL = 2;
    localparam int IRQ1_EN = 0;
    localparam int IRQ2_EN = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0] rs;
        logic       r_w_n;
        logic [7:0] wdata;
    } req_t;

    localparam req_t REQ_RST = '{rs: RS_PORTA, r_w_n: 1'b1, wdata: 8'h00};

endpackage

// File: rtl/pia_bus_master_e_strobe_gen.sv
// Free-running E-cycle divider; one-clock strobe every E_DIV clocks.
module e_strobe_gen #(
    parameter int E_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    output logic e_stb
);

    localparam int CW = $clog2(E_DIV);
    localparam logic [CW-1:0] LAST = CW'(E_DIV - 1);

    logic [CW-1:0] e_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_cnt <= '0;
        end else if (e_cnt == LAST) begin
            e_cnt <= '0;
        end else begin
            e_cnt <= e_cnt + 1'b1;
        end
    end

    assign e_stb = (e_cnt == LAST);

endmodule

// File: rtl/pia_bus_master.sv
// Single-outstanding register access initiator for one PIA.
// Each access is one chip-select clock aligned to the E strobe.
module pia_bus_master
    import pia_bus_pkg::*;
#(
    parameter int E_DIV = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_rs,
    input  logic       req_r_w_n,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       irq,
    output logic       pia_en_e_n,
    output logic       pia_cs,
    output logic [1:0] pia_rs,
    output logic       pia_r_w_n,
    output logic [7:0] pia_data_in,
    input  logic [7:0] pia_data_out,
    input  logic       pia_irq_a,
    input  logic       pia_irq_b
);

    state_t     state;
    state_t     state_nxt;
    req_t       req_q;
    logic [7:0] rdata_q;
    logic       e_stb;
    logic       accept;
    logic       fire;

    e_strobe_gen #(
        .E_DIV(E_DIV)
    ) u_e_strobe (
        .clk  (clk),
        .rst  (rst),
        .e_stb(e_stb)
    );

    assign accept = (state == IDLE) && req_valid;
    assign fire   = (state == WAIT) && e_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= REQ_RST;
            rdata_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= '{rs: req_rs, r_w_n: req_r_w_n, wdata: req_wdata};
            end
            // PIA read data is combinational, so it is valid at the cs edge
            if (fire) begin
                rdata_q <= req_q.r_w_n ? pia_data_out : 8'h00;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        pia_cs      = 1'b0;
        pia_r_w_n   = 1'b1;
        pia_data_in = 8'h00;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                pia_cs      = e_stb;
                pia_r_w_n   = req_q.r_w_n;
                pia_data_in = req_q.wdata;
                if (e_stb) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_rdata  = rdata_q;
    assign pia_rs     = req_q.rs;
    assign pia_en_e_n = e_stb;
    assign irq        = pia_irq_a | pia_irq_b;

endmodule

// File: tb/tb_pia_bus_master.sv
// Scoreboard bench for pia_bus_master with a small PIA responder model.
module tb_pia_bus_master;
    import pia_bus_pkg::*;

    localparam int E_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_rs = 2'd0;
    logic       req_r_w_n = 1'b1;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       irq;
    logic       pia_en_e_n;
    logic       pia_cs;
    logic [1:0] pia_rs;
    logic       pia_r_w_n;
    logic [7:0] pia_data_in;
    logic [7:0] pia_data_out;
    logic       pia_irq_a;
    logic       pia_irq_b;

    pia_bus_master #(
        .E_DIV(E_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_r_w_n   (req_r_w_n),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .irq         (irq),
        .pia_en_e_n  (pia_en_e_n),
        .pia_cs      (pia_cs),
        .pia_rs      (pia_rs),
        .pia_r_w_n   (pia_r_w_n),
        .pia_data_in (pia_data_in),
        .pia_data_out(pia_data_out),
        .pia_irq_a   (pia_irq_a),
        .pia_irq_b   (pia_irq_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cs_cnt  = 0;
    int tb_ecnt = 0;
    logic [7:0] exp_q[$];

    // PIA responder: port A/B registers, CA1 edge flag, irq A
    logic       pia_rst = 1'b1;
    logic       ca1_i = 1'b0;
    logic       ca1_q;
    logic       irq_b_drv = 1'b0;
    logic [7:0] pa_i = 8'h00;
    logic [7:0] cra, ddra, ora, crb, ddrb, orb;
    logic       ca1_edge;

    assign ca1_edge  = cra[1] ? (ca1_i & ~ca1_q) : (~ca1_i & ca1_q);
    assign pia_irq_a = cra[7] & cra[IRQ1_EN];
    assign pia_irq_b = irq_b_drv;

    always_comb begin
        pia_data_out = 8'h00;
        case (pia_rs)
            RS_PORTA: pia_data_out = cra[DDR_SEL] ?
                                     ((pa_i & ~ddra) | (ora & ddra)) : ddra;
            RS_CTRLA: pia_data_out = cra;
            RS_PORTB: pia_data_out = crb[DDR_SEL] ? orb : ddrb;
            default:  pia_data_out = crb;
        endcase
    end

    always @(posedge clk) begin
        if (pia_rst) begin
            cra <= 8'h00; ddra <= 8'h00; ora <= 8'h00;
            crb <= 8'h00; ddrb <= 8'h00; orb <= 8'h00;
            ca1_q <= 1'b0;
        end else begin
            ca1_q <= ca1_i;
            if (ca1_edge) cra[7] <= 1'b1;
            if (pia_cs && pia_en_e_n) begin
                if (!pia_r_w_n) begin
                    case (pia_rs)
                        RS_PORTA: if (cra[DDR_SEL]) ora <= pia_data_in;
                                  else ddra <= pia_data_in;
                        RS_CTRLA: cra[5:0] <= pia_data_in[5:0];
                        RS_PORTB: if (crb[DDR_SEL]) orb <= pia_data_in;
                                  else ddrb <= pia_data_in;
                        default:  crb[5:0] <= pia_data_in[5:0];
                    endcase
                end else if (pia_rs == RS_PORTA && cra[DDR_SEL]) begin
                    cra[7:6] <= 2'b00;
                end
            end
        end
    end

    // Independent E phase, cycle and cs-pulse bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pia_cs) cs_cnt <= cs_cnt + 1;
        if (rst) tb_ecnt <= 0;
        else tb_ecnt <= (tb_ecnt == E_DIV - 1) ? 0 : tb_ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] rs, input logic rnw,
                        input logic [7:0] wd, input logic [7:0] exp,
                        input int phase, input int stall);
        int n, acc_cyc, acc_e, exp_lat, cs0, bad_rdy, bad_dat;
        logic seen;
        logic [7:0] held, q;
        n = 0;
        @(negedge clk);
        while (!(req_ready && (phase < 0 || tb_ecnt == phase)) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy", req_ready, 1);
        exp_q.push_back(exp);
        req_rs = rs; req_r_w_n = rnw; req_wdata = wd; req_valid = 1'b1;
        acc_cyc = cyc; acc_e = tb_ecnt; cs0 = cs_cnt;
        exp_lat = (acc_e == E_DIV - 1) ? E_DIV : E_DIV - 1 - acc_e;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0; n = 0;
        while (!seen && n < 3 * E_DIV) begin
            if (pia_cs) seen = 1'b1;
            else begin
                chk("wait_rdy", req_ready, 0);
                @(negedge clk);
                n++;
            end
        end
        chk("cs_seen", seen, 1);
        if (seen) begin
            chk("cs_lat", cyc - acc_cyc, exp_lat);
            chk("cs_en", pia_en_e_n, 1);
            chk("cs_rs", pia_rs, rs);
            chk("cs_rw", pia_r_w_n, rnw);
            chk("cs_wd", pia_data_in, wd);
        end
        @(negedge clk);
        chk("rsp_v", rsp_valid, 1);
        held = rsp_rdata;
        bad_rdy = 0; bad_dat = 0;
        if (stall > 0) begin
            req_rs = ~rs; req_r_w_n = 1'b1; req_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (req_ready !== 1'b0) bad_rdy++;
                if (rsp_rdata !== held || rsp_valid !== 1'b1) bad_dat++;
            end
            req_valid = 1'b0;
            chk("stall_rdy", bad_rdy, 0);
            chk("stall_dat", bad_dat, 0);
        end
        q = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("rdata", rsp_rdata, q);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("cs_once", cs_cnt - cs0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cs0, badv;
        logic [7:0] ora0;
        repeat (3) @(negedge clk);
        pia_rst = 1'b0;
        chk("rst_rdy", req_ready, 1);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rd", rsp_rdata, 8'h00);
        chk("rst_cs", pia_cs, 0);
        chk("rst_rw", pia_r_w_n, 1);
        chk("rst_rs", pia_rs, 0);
        chk("rst_wd", pia_data_in, 8'h00);
        chk("rst_en", pia_en_e_n, 0);
        rst = 1'b0;

        // Port A output setup: DDR first, then output register
        xfer(RS_CTRLA, 1'b0, 8'h00, 8'h00, -1, 0);
        xfer(RS_PORTA, 1'b0, 8'hFF, 8'h00, -1, 0);
        xfer(RS_CTRLA, 1'b0, 8'h04, 8'h00, -1, 0);
        xfer(RS_PORTA, 1'b0, 8'hA5, 8'h00, -1, 0);
        chk("pa_o", ora, 8'hA5);
        chk("pa_oe", ddra, 8'hFF);

        // Port A input read
        xfer(RS_CTRLA, 1'b0, 8'h00, 8'h00, -1, 0);
        xfer(RS_PORTA, 1'b0, 8'h00, 8'h00, -1, 0);
        xfer(RS_CTRLA, 1'b0, 8'h04, 8'h00, -1, 0);
        pa_i = 8'h3C;
        xfer(RS_PORTA, 1'b1, 8'h00, 8'h3C, -1, 0);
        xfer(RS_CTRLA, 1'b1, 8'h00, 8'h04, -1, 0);

        // Accept in every E phase: latency 1..E_DIV
        for (int p = 0; p < E_DIV; p++)
            xfer(RS_CTRLA, 1'b1, 8'h00, 8'h04, p, 0);
        xfer(RS_PORTB, 1'b0, 8'h5A, 8'h00, E_DIV - 1, 0);
        xfer(RS_PORTB, 1'b1, 8'h00, 8'h5A, 0, 0);

        // CA1 rising-edge interrupt, cleared by port A data read
        xfer(RS_CTRLA, 1'b0, 8'h07, 8'h00, -1, 0);
        @(negedge clk);
        chk("irq_idle", irq, 0);
        ca1_i = 1'b1;
        @(negedge clk);
        ca1_i = 1'b0;
        @(negedge clk);
        chk("irq_set", irq, 1);
        xfer(RS_CTRLA, 1'b1, 8'h00, 8'h87, -1, 0);
        chk("irq_hold", irq, 1);
        xfer(RS_PORTA, 1'b1, 8'h00, 8'h3C, -1, 0);
        chk("irq_clr", irq, 0);
        irq_b_drv = 1'b1;
        #1;
        chk("irq_b", irq, 1);
        irq_b_drv = 1'b0;
        #1;
        chk("irq_b0", irq, 0);

        // Response back-pressure with a competing request held
        xfer(RS_CTRLA, 1'b1, 8'h00, 8'h07, -1, 10);
        xfer(RS_PORTA, 1'b1, 8'h00, 8'h3C, -1, 0);

        // Reset while an access is pending in WAIT
        ora0 = ora;
        @(negedge clk);
        while (!(req_ready && tb_ecnt == E_DIV - 1)) @(negedge clk);
        cs0 = cs_cnt;
        req_rs = RS_PORTA; req_r_w_n = 1'b0; req_wdata = 8'h11;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_in", req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy2", req_ready, 1);
        badv = 0;
        for (int i = 0; i < 2 * E_DIV; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) badv++;
        end
        chk("rst_norsp", badv, 0);
        chk("rst_nocs", cs_cnt - cs0, 0);
        chk("rst_ora", ora, ora0);
        xfer(RS_CTRLA, 1'b1, 8'h00, 8'h07, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
